// File: rtl/char_rotate_seq.sv
// Rotation sequencer for the 3-character 2-bit-code HEX display: latches codes, steps rotation
// on a prescaled tick or manual step. Optional reverse direction via CHAR_ROTATE_REVERSE_EN (adds port dir).
module char_rotate_seq #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       load,
    input  logic [1:0] c0_in,
    input  logic [1:0] c1_in,
    input  logic [1:0] c2_in,
    input  logic       run,
    input  logic       step,
`ifdef CHAR_ROTATE_REVERSE_EN
    input  logic       dir,
`endif
    output logic [1:0] sel,
    output logic [1:0] d0,
    output logic [1:0] d1,
    output logic [1:0] d2,
    output logic       tick
);

    // state | meaning
    // ROT0  | unrotated, sel=00
    // ROT1  | rotated by one, sel=10
    // ROT2  | rotated by two, sel=01
    // Encoding equals the mux-chain select so sel is the state register itself.
    typedef enum logic [1:0] {
        ROT0 = 2'b00,
        ROT1 = 2'b10,
        ROT2 = 2'b01
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             step_q;
    logic [1:0]       c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
    logic             adv;
    logic             rev;

`ifdef CHAR_ROTATE_REVERSE_EN
    assign rev = dir;
`else
    assign rev = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= ROT0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            step_q  <= 1'b0;
            c0_q    <= 2'b00;
            c1_q    <= 2'b00;
            c2_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            step_q  <= step;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        c0_d    = c0_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        adv     = 1'b0;

        if (load) begin
            c0_d    = c0_in;
            c1_d    = c1_in;
            c2_d    = c2_in;
            state_d = ROT0;
            cnt_d   = '0;
        end else if (run) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                adv    = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            // step edges are only honoured while paused; nothing is queued during run
            adv = step & ~step_q;
        end

        if (adv) begin
            if (rev) begin
                case (state_q)
                    ROT0:    state_d = ROT2;
                    ROT2:    state_d = ROT1;
                    default: state_d = ROT0;
                endcase
            end else begin
                case (state_q)
                    ROT0:    state_d = ROT1;
                    ROT1:    state_d = ROT2;
                    default: state_d = ROT0;
                endcase
            end
        end
    end

    always_comb begin
        d0 = c0_q;
        d1 = c1_q;
        d2 = c2_q;
        case (state_q)
            ROT1: begin
                d0 = c1_q;
                d1 = c2_q;
                d2 = c0_q;
            end
            ROT2: begin
                d0 = c2_q;
                d1 = c0_q;
                d2 = c1_q;
            end
            default: ;
        endcase
    end

    assign sel  = state_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_char_rotate_seq.sv
// Self-checking bench for char_rotate_seq: a TICK_DIV=4 and a TICK_DIV=1 instance share inputs and are
// compared every cycle against a position-index model; directed steps followed by random stimulus.
module tb_char_rotate_seq;

    logic       CLOCK_50;
    logic       RESET, load, run, step, dir;
    logic [1:0] c0_in, c1_in, c2_in;
    logic [1:0] sel0, d00, d10, d20;
    logic [1:0] sel1, d01, d11, d21;
    logic       tick0, tick1;

    int n_cmp = 0;
    int n_err = 0;

`ifdef CHAR_ROTATE_REVERSE_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    char_rotate_seq #(.TICK_DIV(4), .CNT_W(3)) dut0 (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .load(load),
        .c0_in(c0_in), .c1_in(c1_in), .c2_in(c2_in), .run(run), .step(step),
`ifdef CHAR_ROTATE_REVERSE_EN
        .dir(dir),
`endif
        .sel(sel0), .d0(d00), .d1(d10), .d2(d20), .tick(tick0)
    );

    char_rotate_seq #(.TICK_DIV(1), .CNT_W(1)) dut1 (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .load(load),
        .c0_in(c0_in), .c1_in(c1_in), .c2_in(c2_in), .run(run), .step(step),
`ifdef CHAR_ROTATE_REVERSE_EN
        .dir(dir),
`endif
        .sel(sel1), .d0(d01), .d1(d11), .d2(d21), .tick(tick1)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Model: codes, rotation position 0..2 (d_i = code[(i+pos)%3]) and prescaler count per instance.
    int m_c[2][3];
    int m_pos[2];
    int m_cnt[2];
    bit m_tick[2];
    bit m_stepq;
    int m_div[2] = '{4, 1};

    function automatic logic [1:0] sel_of(int pos);
        return (pos == 0) ? 2'b00 : (pos == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit rise;
        int stepsz;
        rise   = step && !m_stepq && !run;
        stepsz = (REV_EN && dir) ? 2 : 1;
        for (int k = 0; k < 2; k++) begin
            if (RESET) begin
                m_c[k] = '{0, 0, 0};
                m_pos[k] = 0; m_cnt[k] = 0; m_tick[k] = 0;
            end else if (load) begin
                m_c[k] = '{int'(c0_in), int'(c1_in), int'(c2_in)};
                m_pos[k] = 0; m_cnt[k] = 0; m_tick[k] = 0;
            end else if (run) begin
                if (m_cnt[k] == m_div[k] - 1) begin
                    m_cnt[k] = 0; m_tick[k] = 1;
                    m_pos[k] = (m_pos[k] + stepsz) % 3;
                end else begin
                    m_cnt[k]++; m_tick[k] = 0;
                end
            end else begin
                m_tick[k] = 0;
                if (rise) m_pos[k] = (m_pos[k] + stepsz) % 3;
            end
        end
        m_stepq = RESET ? 1'b0 : step;
    endtask

    task automatic compare_all();
        chk("sel0", {2'b0, sel0}, {2'b0, sel_of(m_pos[0])});
        chk("d0_0", {2'b0, d00}, 4'(m_c[0][(0 + m_pos[0]) % 3]));
        chk("d1_0", {2'b0, d10}, 4'(m_c[0][(1 + m_pos[0]) % 3]));
        chk("d2_0", {2'b0, d20}, 4'(m_c[0][(2 + m_pos[0]) % 3]));
        chk("tick0", {3'b0, tick0}, {3'b0, m_tick[0]});
        chk("sel1", {2'b0, sel1}, {2'b0, sel_of(m_pos[1])});
        chk("d0_1", {2'b0, d01}, 4'(m_c[1][(0 + m_pos[1]) % 3]));
        chk("d2_1", {2'b0, d21}, 4'(m_c[1][(2 + m_pos[1]) % 3]));
        chk("tick1", {3'b0, tick1}, {3'b0, m_tick[1]});
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    initial begin
        bit found;
        int ticks;
        RESET = 1'b1; load = 1'b0; run = 1'b0; step = 1'b0; dir = 1'b0;
        c0_in = 2'b00; c1_in = 2'b00; c2_in = 2'b00;
        m_stepq = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_c[k] = '{0, 0, 0}; m_pos[k] = 0; m_cnt[k] = 0; m_tick[k] = 0;
        end
        #2;

        // 1: reset, then paused idle
        cyc(1);
        chk("rst_sel", {2'b0, sel0}, 4'h0);
        chk("rst_tick", {3'b0, tick0}, 4'h0);
        RESET = 1'b0;
        cyc(10);

        // 2: load and auto-rotate
        c0_in = 2'b01; c1_in = 2'b10; c2_in = 2'b11; load = 1'b1;
        cyc(1);
        chk("t2_d0_load", {2'b0, d00}, 4'h1);
        chk("t2_d2_load", {2'b0, d20}, 4'h3);
        load = 1'b0; run = 1'b1;
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (tick0) ticks++;
            if (i == 3) chk("t2_sel_rot1", {2'b0, sel0}, 4'h2);
            if (i == 7) chk("t2_d0_rot2", {2'b0, d00}, 4'h3);
        end
        chk("t2_tick_count", 4'(ticks), 4'd3);

        // 3: manual step while paused, ignored while running
        run = 1'b0; cyc(2);
        step = 1'b1; cyc(3);
        step = 1'b0; cyc(2);
        run = 1'b1; step = 1'b1; cyc(6);
        run = 1'b0; cyc(3);
        step = 1'b0; cyc(1);
        step = 1'b1; cyc(1);
        step = 1'b0; cyc(2);

        // 4: load in the same cycle a tick would fire
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_cnt[0] == 3) begin found = 1'b1; break; end
            cyc(1);
        end
        chk("t4_wait", {3'b0, found}, 4'h1);
        c0_in = 2'b11; c1_in = 2'b01; c2_in = 2'b10; load = 1'b1;
        cyc(1);
        chk("t4_tick_blocked", {3'b0, tick0}, 4'h0);
        chk("t4_sel", {2'b0, sel0}, 4'h0);
        load = 1'b0;
        cyc(3);
        chk("t4_no_early_tick", {3'b0, tick0}, 4'h0);
        cyc(1);
        chk("t4_tick_after4", {3'b0, tick0}, 4'h1);

        // 5: reset mid-ROT2 while running; TICK_DIV=1 instance cycles each clock
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (m_pos[0] == 2) begin found = 1'b1; break; end
            cyc(1);
        end
        chk("t5_wait", {3'b0, found}, 4'h1);
        RESET = 1'b1; cyc(1);
        chk("t5_rst_d0", {2'b0, d00}, 4'h0);
        chk("t5_rst_sel", {2'b0, sel0}, 4'h0);
        RESET = 1'b0;
        cyc(1); chk("t5_div1_a", {2'b0, sel1}, 4'h2);
        cyc(1); chk("t5_div1_b", {2'b0, sel1}, 4'h1);
        cyc(1); chk("t5_div1_c", {2'b0, sel1}, 4'h0);

`ifdef CHAR_ROTATE_REVERSE_EN
        // 6: reverse order
        dir = 1'b1; c0_in = 2'b01; c1_in = 2'b10; c2_in = 2'b11; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(4); chk("t6_sel_a", {2'b0, sel0}, 4'h1); chk("t6_d0_a", {2'b0, d00}, 4'h3);
        cyc(4); chk("t6_sel_b", {2'b0, sel0}, 4'h2); chk("t6_d0_b", {2'b0, d00}, 4'h2);
        run = 1'b0; step = 1'b0; cyc(1);
        step = 1'b1; cyc(2);
        step = 1'b0; dir = 1'b0; run = 1'b1;
`endif

        // random phase
        for (int i = 0; i < 600; i++) begin
            RESET = ($urandom_range(0, 59) == 0);
            load  = ($urandom_range(0, 14) == 0);
            run   = ($urandom_range(0, 3) != 0);
            step  = $urandom_range(0, 1);
            dir   = $urandom_range(0, 1);
            c0_in = 2'($urandom_range(0, 3));
            c1_in = 2'($urandom_range(0, 3));
            c2_in = 2'($urandom_range(0, 3));
            cyc(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
